// File: rtl/alarma_ctrl.sv
// Alarm controller: debounced sensor trigger, exit delay, timed or latching siren.
// Define ALARMA_LATCH_EN to make ALARM hold until disarm/reset (no siren timer).
module alarma_ctrl #(
  parameter int DEBOUNCE   = 4,
  parameter int EXIT_DELAY = 16,
  parameter int SIREN_TIME = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       disarm,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       siren,
  output logic       armed,
  output logic [1:0] state,
  output logic [3:0] trip_count
);
  localparam int DbW  = $clog2(DEBOUNCE + 1);
  localparam int DlyW = $clog2(EXIT_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMING = 2'b01,
    ARMED  = 2'b10,
    ALARM  = 2'b11
  } stateT;

  stateT           curState, nextState;
  logic            trigReg;
  logic [DbW-1:0]  dbCnt;
  logic            trigValid;
  logic [DlyW-1:0] delayTmr;
  logic            delayDone;

  assign trigValid = (dbCnt == DbW'(DEBOUNCE));
  assign delayDone = (delayTmr == DlyW'(EXIT_DELAY - 1));

`ifndef ALARMA_LATCH_EN
  localparam int SirW = $clog2(SIREN_TIME + 1);
  logic [SirW-1:0] sirenTmr;
  logic            sirenDone;
  assign sirenDone = (sirenTmr == SirW'(SIREN_TIME - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      trigReg <= 1'b0;
      dbCnt   <= '0;
    end else begin
      trigReg <= ~a | ~b | c;
      if (!trigReg)        dbCnt <= '0;
      else if (!trigValid) dbCnt <= dbCnt + 1'b1;
    end
  end

  always_comb begin
    nextState = curState;
    if (disarm) begin
      nextState = IDLE;
    end else begin
      case (curState)
        IDLE:    if (arm) nextState = ARMING;
        ARMING:  if (delayDone) nextState = ARMED;
        ARMED:   if (trigValid) nextState = ALARM;
        ALARM: begin
`ifndef ALARMA_LATCH_EN
          if (sirenDone) nextState = ARMED;
`endif
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Timers only advance while staying in their state, so any entry clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState   <= IDLE;
      delayTmr   <= '0;
      trip_count <= '0;
    end else begin
      curState <= nextState;
      if (curState == ARMING && nextState == ARMING && !delayDone)
        delayTmr <= delayTmr + 1'b1;
      else
        delayTmr <= '0;
      if (curState == ARMED && nextState == ALARM && trip_count != 4'hf)
        trip_count <= trip_count + 4'd1;
    end
  end

`ifndef ALARMA_LATCH_EN
  always_ff @(posedge clk) begin
    if (reset)
      sirenTmr <= '0;
    else if (curState == ALARM && nextState == ALARM && !sirenDone)
      sirenTmr <= sirenTmr + 1'b1;
    else
      sirenTmr <= '0;
  end
`endif

  assign state = curState;
  assign siren = (curState == ALARM);
  assign armed = curState[1];
endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl with default parameters (4/16/64).
module tb_alarma_ctrl;
  logic       clk = 1'b0;
  logic       reset, arm, disarm, a, b, c;
  logic       siren, armed;
  logic [1:0] state;
  logic [3:0] trip_count;
  int         nChk  = 0;
  int         nPass = 0;

  alarma_ctrl dut (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
    .a(a), .b(b), .c(c),
    .siren(siren), .armed(armed), .state(state), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nChk++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input int st, input int sr, input int ar, input int tc);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".siren"}, int'(siren), sr);
    chk({tag, ".armed"}, int'(armed), ar);
    chk({tag, ".trips"}, int'(trip_count), tc);
  endtask

  task automatic doArm();
    arm = 1'b1; step(1); arm = 1'b0;
    step(16);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; disarm = 1'b0; a = 1'b1; b = 1'b1; c = 1'b0;
    step(2);
    chkOut("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // exit delay: 16 cycles in ARMING, re-arm mid-delay ignored
    arm = 1'b1; step(1); arm = 1'b0;
    chk("arming.enter", int'(state), 1);
    step(7); arm = 1'b1; step(1); arm = 1'b0;
    step(7);
    chk("arming.last", int'(state), 1);
    step(1);
    chkOut("armed.enter", 2, 0, 1, 0);

    // 3-cycle pulse is shorter than debounce
    a = 1'b0; step(3); a = 1'b1;
    step(10);
    chkOut("pulse", 2, 0, 1, 0);

    // held trigger: ALARM after 1 reg + 4 debounce + 1 FSM edge
    a = 1'b0; step(5);
    chk("trip.early", int'(state), 2);
    step(1);
    chkOut("trip", 3, 1, 1, 1);
    a = 1'b1;

`ifndef ALARMA_LATCH_EN
    step(63);
    chkOut("siren.last", 3, 1, 1, 1);
    step(1);
    chkOut("siren.done", 2, 0, 1, 1);
    step(3);
    chk("rearmed.quiet", int'(state), 2);

    a = 1'b0; step(6);
    chkOut("retrip", 3, 1, 1, 2);
    step(64);
    chk("retrip.back", int'(state), 2);
    step(1);
    chkOut("retrip.again", 3, 1, 1, 3);
    step(65 * 15);
    chkOut("saturate", 3, 1, 1, 15);
    a = 1'b1;
    disarm = 1'b1; step(1); disarm = 1'b0;
    chkOut("disarm.alarm", 0, 0, 0, 15);
`else
    step(1000);
    chkOut("latch.hold", 3, 1, 1, 1);
    disarm = 1'b1; step(1); disarm = 1'b0;
    chkOut("disarm.alarm", 0, 0, 0, 1);
`endif

    // disarm in ARMING, ARMED; arm+disarm together in IDLE
    arm = 1'b1; step(1); arm = 1'b0;
    step(3);
    disarm = 1'b1; step(1); disarm = 1'b0;
    chk("disarm.arming", int'(state), 0);
    chk("disarm.arming.armed", int'(armed), 0);
    doArm();
    chk("rearm", int'(state), 2);
    disarm = 1'b1; step(1); disarm = 1'b0;
    chk("disarm.armed", int'(state), 0);
    chk("disarm.armed.armed", int'(armed), 0);
    arm = 1'b1; disarm = 1'b1; step(2); arm = 1'b0; disarm = 1'b0;
    chk("arm+disarm", int'(state), 0);

    // reset mid-ALARM beats disarm and clears everything
    doArm();
    a = 1'b0; step(6);
    chk("alarm.again", int'(state), 3);
    reset = 1'b1; disarm = 1'b1; step(1);
    chkOut("reset.alarm", 0, 0, 0, 0);
    reset = 1'b0; disarm = 1'b0; a = 1'b1;
    arm = 1'b1; step(1); arm = 1'b0;
    chk("post.reset.arm", int'(state), 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule

// File: doc/alarma_ctrl.md
ALARMA_CTRL -- requirements
Module: alarma_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive cycles the raw trigger must be held before it counts as valid (range 1..255).
REQ-002 Parameter EXIT_DELAY, default 16: cycles spent in ARMING before the block reaches ARMED (range 1..65535).
REQ-003 Parameter SIREN_TIME, default 64: cycles the siren stays on per trip when latching is off (range 1..65535).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 arm  input  1  arm request, level-sampled each cycle.
REQ-007 disarm  input  1  disarm request, level-sampled each cycle.
REQ-008 a, b, c  input  1 each  raw sensor lines.
REQ-009 siren  output  1  alarm output, registered.
REQ-010 armed  output  1  high in ARMED or ALARM, registered.
REQ-011 state  output  2  FSM encoding: IDLE=00, ARMING=01, ARMED=10, ALARM=11.
REQ-012 trip_count  output  4  number of ALARM entries since reset, saturating.

Function
REQ-013 Raw trigger shall be trig = ~a | ~b | c, registered once (1 cycle latency).
REQ-014 Debounce counter shall increment while registered trig=1, clear to 0 when trig=0, and saturate at DEBOUNCE; trig_valid=1 iff counter==DEBOUNCE.
REQ-015 With trig held from cycle t, trig_valid shall first be high in cycle t+1+DEBOUNCE.
REQ-016 IDLE: arm=1 -> ARMING, clear delay timer; otherwise stay.
REQ-017 ARMING: timer counts to EXIT_DELAY-1, then -> ARMED; trig_valid ignored.
REQ-018 ARMED: trig_valid=1 -> ALARM, clear siren timer, increment trip_count.
REQ-019 ALARM: siren=1; timer reaches SIREN_TIME-1 -> ARMED (re-armed, siren=0 next cycle).
REQ-020 ALARM re-entry from ARMED with trig_valid still high shall occur on the cycle after returning, counting another trip.
REQ-021 disarm=1 shall force IDLE from any state on the next edge, with priority over arm, timers, and trig_valid.
REQ-022 Simultaneous arm=1 and disarm=1 in IDLE -> stay IDLE.
REQ-023 arm=1 outside IDLE shall be ignored (no timer restart).
REQ-024 trip_count shall hold at 15 once reached; disarm shall not clear it.
REQ-025 siren shall be 1 exactly in ALARM and armed exactly in ARMED/ALARM, both derived from registered state (no combinational input-to-output path).
REQ-026 Timers shall be wide enough for their parameter and never wrap; a timer is cleared on every state entry.

Reset
REQ-027 reset=1 at a rising edge -> state=IDLE, siren=0, armed=0, trip_count=0, all timers, debounce counter, and trig register 0.
REQ-028 Reset shall take priority over disarm, arm, and every other input, including mid-ARMING and mid-ALARM.
REQ-029 After reset deasserts, the first transition shall be possible on the next edge.

Configuration
REQ-030 Macro ALARMA_LATCH_EN defined: ALARM shall not time out; siren stays 1 until disarm or reset, and the siren timer is not built.
REQ-031 Macro ALARMA_LATCH_EN undefined: ALARM exits to ARMED after SIREN_TIME cycles per REQ-019.

Verification
REQ-032 reset 2 cycles, a=1 b=1 c=0, arm pulse 1 cycle -> state=01 for 16 cycles, then 10; siren=0, trip_count=0.
REQ-033 In ARMED, a=0 held -> siren=1 at 1+4 cycles plus 1 FSM edge after a fell, trip_count=1; a=0 pulse of 3 cycles -> no alarm.
REQ-034 ALARMA_LATCH_EN undefined, trigger released after trip -> siren high exactly 64 cycles, state returns to 10; trigger held -> trips repeat and trip_count saturates at 15 after 15+ trips.
REQ-035 disarm=1 during ARMING, ARMED, and ALARM (one run each) -> state=00, siren=0, armed=0 next cycle; arm and disarm high together in IDLE -> stays 00.
REQ-036 ALARMA_LATCH_EN defined, trip -> siren stays 1 for 1000 cycles until disarm; reset mid-ALARM -> all outputs 0 next cycle.
